ddr3_init_refresh_seq: RTL and testbench
========================================

Name: ddr3_init_refresh_seq

Overview:
- Synthesizable command-generation stage that drives the DDR3 command and address pins of ddr3_interface (cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt, rst_n).
- Performs the JEDEC power-up and initialization sequence: reset hold, CKE enable, MR2/MR3/MR1/MR0 programming, ZQCL calibration.
- After initialization, schedules periodic PRECHARGE-ALL + REFRESH pairs under a request/acknowledge handshake with the read/write scheduler.

Parameters:
- BA_BITS, 3, bank address width
- ADDR_BITS, 14, address bus width (1024Mb device)
- CNT_W, 16, width of the delay and refresh counters
- T_RESET, 200, cycles ddr_rst_n is held low after rst_n deasserts
- T_CKE, 500, cycles from ddr_rst_n high to cke high
- T_XPR, 64, NOP cycles after cke high before the first MRS
- T_MRD, 4, cycles between consecutive MRS commands
- T_MOD, 12, cycles from MR0 to ZQCL
- T_ZQINIT, 512, cycles from ZQCL to init_done
- T_RP, 6, cycles from PRECHARGE-ALL to REFRESH
- T_RFC, 44, cycles from REFRESH to end of ref_busy
- T_REFI, 3120, refresh interval in cycles
- MR0_VAL / MR1_VAL / MR2_VAL / MR3_VAL, 14'h0520 / 14'h0044 / 14'h0000 / 14'h0000, mode register contents

Ports:
- ck  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ref_ack  in  1  scheduler grants the bus for refresh (all banks may be closed)
- ddr_rst_n  out  1  DRAM RESET#
- cke  out  1  clock enable
- cs_n  out  1  chip select
- ras_n  out  1  row address strobe
- cas_n  out  1  column address strobe
- we_n  out  1  write enable
- odt  out  1  on-die termination (held 0 by this block)
- ba  out  BA_BITS  bank address
- addr  out  ADDR_BITS  address
- init_done  out  1  initialization complete (sticky until reset)
- ref_req  out  1  refresh due
- ref_busy  out  1  refresh sequence in progress
- ref_overflow  out  1  sticky: more than 8 refreshes owed

Behaviour:
- Clock and reset: one clock ck. Reset is synchronous on rst_n, active-low. All outputs are registered.
- Reset values: ddr_rst_n=0, cke=0, cs_n=1, ras_n=1, cas_n=1, we_n=1, odt=0, ba=0, addr=0, init_done=0, ref_req=0, ref_busy=0, ref_overflow=0, state=RST_HOLD, all counters 0.
- Reset mid-operation returns to RST_HOLD on the next edge; there is no partial resume.
- Command encoding {cs_n,ras_n,cas_n,we_n}:
  - NOP = 0111
  - MRS = 0000
  - REF = 0001
  - PRE = 0010
  - ZQCL = 0110 with addr[10]=1
  - Any non-command cycle after cke rises drives NOP.
- States: RST_HOLD -> CKE_WAIT -> XPR_WAIT -> MRS2 -> MRS3 -> MRS1 -> MRS0 -> ZQCL -> ZQ_WAIT -> IDLE <-> {PRE_ALL -> REF_CMD}.
- Delay counting: a command state drives its command for exactly one cycle on entry, loads the delay counter with (T_x - 1), then drives NOP until the counter reaches 0. Consecutive commands are therefore spaced exactly T_x cycles, edge to edge.
- RST_HOLD: ddr_rst_n=0 for T_RESET cycles, then ddr_rst_n=1.
- CKE_WAIT: T_CKE cycles, then cke=1.
- XPR_WAIT: T_XPR cycles of NOP.
- MRS commands:
  - Issue order MR2, MR3, MR1, MR0, spaced by T_MRD.
  - ba = register index.
  - addr = MRx_VAL.
- ZQCL: issued T_MOD cycles after MR0, with ba=0. init_done rises T_ZQINIT cycles after ZQCL and the FSM enters IDLE.
- Refresh timer:
  - Free-running from init_done.
  - On reaching T_REFI-1 it wraps to 0 and increments owed (4-bit, saturating at 9).
  - owed > 8 sets ref_overflow.
  - ref_req = (owed != 0) while in IDLE.
- Refresh handshake:
  - In IDLE with ref_req=1 and ref_ack=1: enter PRE_ALL, issue PRE with addr[10]=1.
  - ref_busy rises on the PRE cycle.
  - After T_RP: issue REF.
  - After T_RFC: decrement owed, drop ref_busy, return to IDLE.
  - ref_req is 0 while ref_busy=1.
  - If a timer expiry coincides with the REF completion decrement, owed is unchanged (increment and decrement cancel).
- ref_ack before init_done is ignored. ref_ack held high with owed=0 has no effect.
- odt stays 0 throughout.

Decomposition:
- Package ddr3_seq_pkg holds:
  - state enum
  - 4-bit command encoding localparams (CMD_NOP, CMD_MRS, CMD_REF, CMD_PRE, CMD_ZQ)
  - cmd_t struct {cs_n, ras_n, cas_n, we_n}
- Sub-module ddr3_refresh_timer contains the T_REFI interval counter, the owed counter and overflow logic. It outputs ref_due, and takes inputs owed_dec and enable.

Test Plan:
- Power-up: release rst_n at cycle 0 -> ddr_rst_n rises at cycle 200, cke at 700, MR2 at 764, MR3 at 768, MR1 at 772, MR0 at 776 (ba=0, addr=14'h0520), ZQCL at 788 with addr[10]=1, init_done at 1300.
- Refresh handshake: hold ref_ack=1 after init -> ref_req at init_done+3120; PRE one cycle later; REF 6 cycles after PRE; ref_busy falls 44 cycles after REF.
- Postponement: hold ref_ack=0 for 9 intervals -> owed saturates at 9 and ref_overflow=1. Then ref_ack=1 -> 9 back-to-back PRE/REF pairs, after which owed=0.
- Mid-init reset: drop rst_n during MRS1 -> next cycle all outputs equal reset values; the sequence replays from RST_HOLD with identical timing.
- Coincident events: timer expiry on the same cycle REF completes with owed=1 -> owed stays 1 and ref_req is reasserted in IDLE.
- Early ack: ref_ack=1 throughout init -> no PRE or REF issued before init_done.

Source files
------------

// File: rtl/ddr3_seq_pkg.sv
// Shared types, command encodings and refresh-debt helpers for the DDR3 init/refresh sequencer.
package ddr3_seq_pkg;

    typedef enum logic [3:0] {
        RST_HOLD,
        CKE_WAIT,
        XPR_WAIT,
        MRS2,
        MRS3,
        MRS1,
        MRS0,
        ZQCL,
        ZQ_WAIT,
        IDLE,
        PRE_ALL,
        REF_CMD
    } state_t;

    typedef struct packed {
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
    } cmd_t;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_MRS   = 4'b0000;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_ZQ    = 4'b0110;
    // Chip deselected: the only legal bus state while CKE is still low.
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    localparam logic [3:0] OWED_MAX       = 4'd9;
    localparam logic [3:0] OWED_OVF_LIMIT = 4'd8;

    // Expiry and completion in the same cycle cancel; the debt saturates at OWED_MAX.
    function automatic logic [3:0] owed_step(input logic [3:0] owed, input logic inc, input logic dec);
        logic [3:0] nxt;
        nxt = owed;
        if (inc && dec) begin
            nxt = owed;
        end else if (inc) begin
            if (owed < OWED_MAX) nxt = owed + 4'd1;
            else                 nxt = owed;
        end else if (dec) begin
            if (owed != 4'd0) nxt = owed - 4'd1;
            else              nxt = owed;
        end else begin
            nxt = owed;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ddr3_init_refresh_seq_timer.sv
// Refresh interval timer: counts tREFI periods, tracks owed refreshes and flags overflow.
module ddr3_refresh_timer
    import ddr3_seq_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int T_REFI = 3120
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_owed_dec,
    output logic o_ref_due,
    output logic o_ref_overflow
);

    localparam logic [CNT_W-1:0] L_REFI = CNT_W'(T_REFI - 1);

    logic [CNT_W-1:0] r_tmr;
    logic [CNT_W-1:0] w_tmr_nxt;
    logic [3:0]       r_owed;
    logic [3:0]       w_owed_nxt;
    logic             r_ovf;
    logic             w_wrap;

    // Interval counter and next owed count.
    always_comb begin
        w_wrap    = 1'b0;
        w_tmr_nxt = '0;
        if (i_enable) begin
            if (r_tmr == L_REFI) begin
                w_wrap    = 1'b1;
                w_tmr_nxt = '0;
            end else begin
                w_tmr_nxt = r_tmr + CNT_W'(1);
            end
        end else begin
            w_tmr_nxt = '0;
        end
        w_owed_nxt = owed_step(r_owed, w_wrap, i_owed_dec);
    end

    // Look-ahead so the parent can register ref_req in the same cycle the debt changes.
    assign o_ref_due      = (w_owed_nxt != 4'd0);
    assign o_ref_overflow = r_ovf;

    // Timer, debt and sticky overflow registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tmr  <= '0;
            r_owed <= 4'd0;
            r_ovf  <= 1'b0;
        end else begin
            r_tmr  <= w_tmr_nxt;
            r_owed <= w_owed_nxt;
            r_ovf  <= r_ovf | (w_owed_nxt > OWED_OVF_LIMIT);
        end
    end

endmodule

// File: rtl/ddr3_init_refresh_seq.sv
// DDR3 command generator: JEDEC power-up/MRS/ZQCL init, then PRE-ALL + REFRESH under a req/ack handshake.
module ddr3_init_refresh_seq
    import ddr3_seq_pkg::*;
#(
    parameter int                   BA_BITS   = 3,
    parameter int                   ADDR_BITS = 14,
    parameter int                   CNT_W     = 16,
    parameter int                   T_RESET   = 200,
    parameter int                   T_CKE     = 500,
    parameter int                   T_XPR     = 64,
    parameter int                   T_MRD     = 4,
    parameter int                   T_MOD     = 12,
    parameter int                   T_ZQINIT  = 512,
    parameter int                   T_RP      = 6,
    parameter int                   T_RFC     = 44,
    parameter int                   T_REFI    = 3120,
    parameter logic [ADDR_BITS-1:0] MR0_VAL   = 14'h0520,
    parameter logic [ADDR_BITS-1:0] MR1_VAL   = 14'h0044,
    parameter logic [ADDR_BITS-1:0] MR2_VAL   = 14'h0000,
    parameter logic [ADDR_BITS-1:0] MR3_VAL   = 14'h0000
) (
    input  logic                 ck,
    input  logic                 rst_n,
    input  logic                 ref_ack,
    output logic                 ddr_rst_n,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 ras_n,
    output logic                 cas_n,
    output logic                 we_n,
    output logic                 odt,
    output logic [BA_BITS-1:0]   ba,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 init_done,
    output logic                 ref_req,
    output logic                 ref_busy,
    output logic                 ref_overflow
);

    localparam logic [CNT_W-1:0]     L_RESET  = CNT_W'(T_RESET - 1);
    localparam logic [CNT_W-1:0]     L_CKE    = CNT_W'(T_CKE - 1);
    localparam logic [CNT_W-1:0]     L_XPR    = CNT_W'(T_XPR - 1);
    localparam logic [CNT_W-1:0]     L_MRD    = CNT_W'(T_MRD - 1);
    localparam logic [CNT_W-1:0]     L_MOD    = CNT_W'(T_MOD - 1);
    localparam logic [CNT_W-1:0]     L_ZQINIT = CNT_W'(T_ZQINIT - 1);
    localparam logic [CNT_W-1:0]     L_RP     = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0]     L_RFC    = CNT_W'(T_RFC - 1);
    localparam logic [ADDR_BITS-1:0] A10      = ADDR_BITS'(14'h0400);

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    cmd_t                 r_cmd, w_cmd_nxt;
    logic [BA_BITS-1:0]   r_ba, w_ba_nxt;
    logic [ADDR_BITS-1:0] r_addr, w_addr_nxt;
    logic                 r_ddr_rst_n, w_ddr_rst_n_nxt;
    logic                 r_cke, w_cke_nxt;
    logic                 r_init_done, w_init_done_nxt;
    logic                 r_ref_req;
    logic                 r_ref_busy;
    logic                 w_owed_dec;
    logic                 w_ref_due;
    logic                 w_ref_overflow;

    ddr3_refresh_timer #(
        .CNT_W  (CNT_W),
        .T_REFI (T_REFI)
    ) u_timer (
        .i_clk          (ck),
        .i_rst_n        (rst_n),
        .i_enable       (r_init_done),
        .i_owed_dec     (w_owed_dec),
        .o_ref_due      (w_ref_due),
        .o_ref_overflow (w_ref_overflow)
    );

    // Next-state and next-command logic; each state issues its command on entry, then waits.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt + CNT_W'(1);
        w_cmd_nxt        = r_cke ? cmd_t'(CMD_NOP) : cmd_t'(CMD_DESEL);
        w_ba_nxt         = '0;
        w_addr_nxt       = '0;
        w_ddr_rst_n_nxt  = r_ddr_rst_n;
        w_cke_nxt        = r_cke;
        w_init_done_nxt  = r_init_done;
        w_owed_dec       = 1'b0;
        case (r_state)
            RST_HOLD: begin
                if (r_cnt == L_RESET) begin
                    w_state_nxt     = CKE_WAIT;
                    w_cnt_nxt       = '0;
                    w_ddr_rst_n_nxt = 1'b1;
                end else begin
                    w_state_nxt = RST_HOLD;
                end
            end
            CKE_WAIT: begin
                if (r_cnt == L_CKE) begin
                    w_state_nxt = XPR_WAIT;
                    w_cnt_nxt   = '0;
                    w_cke_nxt   = 1'b1;
                    w_cmd_nxt   = cmd_t'(CMD_NOP);
                end else begin
                    w_state_nxt = CKE_WAIT;
                end
            end
            XPR_WAIT: begin
                if (r_cnt == L_XPR) begin
                    w_state_nxt = MRS2;
                    w_cnt_nxt   = '0;
                    w_cmd_nxt   = cmd_t'(CMD_MRS);
                    w_ba_nxt    = BA_BITS'(3'd2);
                    w_addr_nxt  = MR2_VAL;
                end else begin
                    w_state_nxt = XPR_WAIT;
                end
            end
            MRS2: begin
                if (r_cnt == L_MRD) begin
                    w_state_nxt = MRS3;
                    w_cnt_nxt   = '0;
                    w_cmd_nxt   = cmd_t'(CMD_MRS);
                    w_ba_nxt    = BA_BITS'(3'd3);
                    w_addr_nxt  = MR3_VAL;
                end else begin
                    w_state_nxt = MRS2;
                end
            end
            MRS3: begin
                if (r_cnt == L_MRD) begin
                    w_state_nxt = MRS1;
                    w_cnt_nxt   = '0;
                    w_cmd_nxt   = cmd_t'(CMD_MRS);
                    w_ba_nxt    = BA_BITS'(3'd1);
                    w_addr_nxt  = MR1_VAL;
                end else begin
                    w_state_nxt = MRS3;
                end
            end
            MRS1: begin
                if (r_cnt == L_MRD) begin
                    w_state_nxt = MRS0;
                    w_cnt_nxt   = '0;
                    w_cmd_nxt   = cmd_t'(CMD_MRS);
                    w_ba_nxt    = BA_BITS'(3'd0);
                    w_addr_nxt  = MR0_VAL;
                end else begin
                    w_state_nxt = MRS1;
                end
            end
            MRS0: begin
                if (r_cnt == L_MOD) begin
                    w_state_nxt = ZQCL;
                    w_cnt_nxt   = '0;
                    w_cmd_nxt   = cmd_t'(CMD_ZQ);
                    w_addr_nxt  = A10;
                end else begin
                    w_state_nxt = MRS0;
                end
            end
            // The ZQ count keeps running across the ZQCL -> ZQ_WAIT hop.
            ZQCL: begin
                w_state_nxt = ZQ_WAIT;
            end
            ZQ_WAIT: begin
                if (r_cnt == L_ZQINIT) begin
                    w_state_nxt     = IDLE;
                    w_cnt_nxt       = '0;
                    w_init_done_nxt = 1'b1;
                end else begin
                    w_state_nxt = ZQ_WAIT;
                end
            end
            IDLE: begin
                w_cnt_nxt = '0;
                if (r_ref_req && ref_ack) begin
                    w_state_nxt = PRE_ALL;
                    w_cmd_nxt   = cmd_t'(CMD_PRE);
                    w_addr_nxt  = A10;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            PRE_ALL: begin
                if (r_cnt == L_RP) begin
                    w_state_nxt = REF_CMD;
                    w_cnt_nxt   = '0;
                    w_cmd_nxt   = cmd_t'(CMD_REF);
                end else begin
                    w_state_nxt = PRE_ALL;
                end
            end
            REF_CMD: begin
                if (r_cnt == L_RFC) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_owed_dec  = 1'b1;
                end else begin
                    w_state_nxt = REF_CMD;
                end
            end
            default: begin
                w_state_nxt = RST_HOLD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered pin drivers.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            r_state     <= RST_HOLD;
            r_cnt       <= '0;
            r_cmd       <= cmd_t'(CMD_DESEL);
            r_ba        <= '0;
            r_addr      <= '0;
            r_ddr_rst_n <= 1'b0;
            r_cke       <= 1'b0;
            r_init_done <= 1'b0;
            r_ref_req   <= 1'b0;
            r_ref_busy  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd       <= w_cmd_nxt;
            r_ba        <= w_ba_nxt;
            r_addr      <= w_addr_nxt;
            r_ddr_rst_n <= w_ddr_rst_n_nxt;
            r_cke       <= w_cke_nxt;
            r_init_done <= w_init_done_nxt;
            r_ref_req   <= (w_state_nxt == IDLE) && w_ref_due;
            r_ref_busy  <= (w_state_nxt == PRE_ALL) || (w_state_nxt == REF_CMD);
        end
    end

    assign ddr_rst_n    = r_ddr_rst_n;
    assign cke          = r_cke;
    assign cs_n         = r_cmd.cs_n;
    assign ras_n        = r_cmd.ras_n;
    assign cas_n        = r_cmd.cas_n;
    assign we_n         = r_cmd.we_n;
    assign odt          = 1'b0;
    assign ba           = r_ba;
    assign addr         = r_addr;
    assign init_done    = r_init_done;
    assign ref_req      = r_ref_req;
    assign ref_busy     = r_ref_busy;
    assign ref_overflow = w_ref_overflow;

endmodule

// File: tb/tb_ddr3_init_refresh_seq.sv
// Directed bench for the DDR3 init/refresh sequencer using the default JEDEC-style timing.
module tb_ddr3_init_refresh_seq;

    logic        ck = 1'b0;
    logic        rst_n;
    logic        ref_ack;
    logic        ddr_rst_n, cke, cs_n, ras_n, cas_n, we_n, odt;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic        init_done, ref_req, ref_busy, ref_overflow;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_pre    = 0;
    int n_ref    = 0;

    ddr3_init_refresh_seq dut (
        .ck           (ck),
        .rst_n        (rst_n),
        .ref_ack      (ref_ack),
        .ddr_rst_n    (ddr_rst_n),
        .cke          (cke),
        .cs_n         (cs_n),
        .ras_n        (ras_n),
        .cas_n        (cas_n),
        .we_n         (we_n),
        .odt          (odt),
        .ba           (ba),
        .addr         (addr),
        .init_done    (init_done),
        .ref_req      (ref_req),
        .ref_busy     (ref_busy),
        .ref_overflow (ref_overflow)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
        cyc++;
    endtask

    task automatic adv_to(input int target);
        while (cyc < target) tick();
    endtask

    function automatic logic [27:0] snap();
        return {ddr_rst_n, cke, cs_n, ras_n, cas_n, we_n, odt, ba, addr,
                init_done, ref_req, ref_busy, ref_overflow};
    endfunction

    function automatic logic [3:0] cmd_now();
        return {cs_n, ras_n, cas_n, we_n};
    endfunction

    // Hand-derived power-up waveform: cycle 0 is the last clock edge with rst_n low.
    function automatic logic [27:0] exp_init(input int c);
        logic        rv, kv, dv;
        logic [3:0]  cm;
        logic [2:0]  b;
        logic [13:0] a;
        rv = (c >= 200);
        kv = (c >= 700);
        dv = (c >= 1300);
        cm = kv ? 4'b0111 : 4'b1111;
        b  = 3'd0;
        a  = 14'h0000;
        case (c)
            764:     begin cm = 4'b0000; b = 3'd2; a = 14'h0000; end
            768:     begin cm = 4'b0000; b = 3'd3; a = 14'h0000; end
            772:     begin cm = 4'b0000; b = 3'd1; a = 14'h0044; end
            776:     begin cm = 4'b0000; b = 3'd0; a = 14'h0520; end
            788:     begin cm = 4'b0110; b = 3'd0; a = 14'h0400; end
            default: begin end
        endcase
        return {rv, kv, cm, 1'b0, b, a, dv, 3'b000};
    endfunction

    initial begin
        rst_n   = 1'b0;
        ref_ack = 1'b1;
        repeat (3) @(posedge ck);
        #1;
        cyc = 0;
        chk("reset", snap(), exp_init(0));
        rst_n = 1'b1;

        // First power-up, interrupted in MRS1 (ack held high the whole time).
        for (int c = 1; c <= 773; c++) begin
            tick();
            chk("init1", snap(), exp_init(c));
        end
        rst_n = 1'b0;
        tick();
        cyc = 0;
        chk("midrst", snap(), exp_init(0));
        rst_n = 1'b1;
        for (int c = 1; c <= 1300; c++) begin
            tick();
            chk("replay", snap(), exp_init(c));
        end

        // First refresh with ack already high.
        adv_to(4419);
        chk("req_early", 28'(ref_req), 28'(1'b0));
        tick();
        chk("req_4420", 28'(ref_req), 28'(1'b1));
        chk("busy_4420", 28'(ref_busy), 28'(1'b0));
        tick();
        chk("pre_cmd", 28'(cmd_now()), 28'(4'b0010));
        chk("pre_addr", 28'(addr), 28'(14'h0400));
        chk("pre_ba", 28'(ba), 28'(3'd0));
        chk("pre_busy", 28'(ref_busy), 28'(1'b1));
        chk("pre_req", 28'(ref_req), 28'(1'b0));
        adv_to(4426);
        chk("rp_nop", 28'(cmd_now()), 28'(4'b0111));
        tick();
        chk("ref_cmd", 28'(cmd_now()), 28'(4'b0001));
        chk("ref_busy", 28'(ref_busy), 28'(1'b1));
        adv_to(4470);
        chk("rfc_busy", 28'(ref_busy), 28'(1'b1));
        tick();
        chk("rfc_done", 28'(ref_busy), 28'(1'b0));
        chk("rfc_req", 28'(ref_req), 28'(1'b0));
        adv_to(5000);
        chk("ack_idle_cmd", 28'(cmd_now()), 28'(4'b0111));
        chk("ack_idle_busy", 28'(ref_busy), 28'(1'b0));
        ref_ack = 1'b0;

        // Postpone nine intervals: debt saturates and overflow sticks.
        adv_to(7540);
        chk("postpone_req", 28'(ref_req), 28'(1'b1));
        adv_to(32499);
        chk("ovf_before", 28'(ref_overflow), 28'(1'b0));
        chk("nobusy_postpone", 28'(ref_busy), 28'(1'b0));
        tick();
        chk("ovf_set", 28'(ref_overflow), 28'(1'b1));
        ref_ack = 1'b1;
        while (cyc < 33100) begin
            tick();
            if (cyc == 32501) chk("burst_first_pre", 28'(cmd_now()), 28'(4'b0010));
            if (cmd_now() == 4'b0010) n_pre++;
            if (cmd_now() == 4'b0001) n_ref++;
        end
        chk("burst_pre_cnt", 28'(n_pre), 28'(9));
        chk("burst_ref_cnt", 28'(n_ref), 28'(9));
        chk("burst_req_clear", 28'(ref_req), 28'(1'b0));
        chk("ovf_sticky", 28'(ref_overflow), 28'(1'b1));
        ref_ack = 1'b0;

        // Expiry lands on the REF completion edge with one refresh owed.
        adv_to(35620);
        chk("req_k11", 28'(ref_req), 28'(1'b1));
        adv_to(38689);
        ref_ack = 1'b1;
        tick();
        chk("co_pre", 28'(cmd_now()), 28'(4'b0010));
        adv_to(38696);
        chk("co_ref", 28'(cmd_now()), 28'(4'b0001));
        adv_to(38739);
        chk("co_busy", 28'(ref_busy), 28'(1'b1));
        tick();
        chk("co_done_busy", 28'(ref_busy), 28'(1'b0));
        chk("co_req_again", 28'(ref_req), 28'(1'b1));
        tick();
        chk("co_pre2", 28'(cmd_now()), 28'(4'b0010));
        adv_to(38791);
        chk("co2_busy", 28'(ref_busy), 28'(1'b0));
        chk("co2_req", 28'(ref_req), 28'(1'b0));
        chk("odt_low", 28'(odt), 28'(1'b0));
        ref_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
